// File: rtl/cmos_capture_multiformat.sv
// cmos_capture_multiformat: DVP sensor capture assembling RAW8/RGB565/RGB888 pixels with frame skip, fps and line-error reporting
//   clk, rst_n       pixel clock, asynchronous active-low reset
//   mode             0 RAW8, 1 RGB565, 2 RGB888, 3 RAW8 (latched at frame start)
//   cmos_vsync/href/data      raw sensor bus
//   cmos_frame_vsync/href/clken/data  aligned output stream, gated by capture_en
//   cmos_fps_rate    frames completed in the last one-second window
//   capture_en       high once the start-up frames have been discarded
//   line_err_cnt     lines ending mid-pixel, saturating
module cmos_capture_multiformat #(
   parameter int         DATA_WIDTH    = 8,
   parameter logic       VSYNC_VALID   = 1'b1,
   parameter logic [3:0] FRAME_WAITCNT = 4'd10,
   parameter int         CLK_FREQ      = 24000000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0]              mode,
   input  logic                    cmos_vsync,
   input  logic                    cmos_href,
   input  logic [DATA_WIDTH-1:0]   cmos_data,
   output logic                    cmos_frame_vsync,
   output logic                    cmos_frame_href,
   output logic                    cmos_frame_clken,
   output logic [3*DATA_WIDTH-1:0] cmos_frame_data,
   output logic [7:0]              cmos_fps_rate,
   output logic                    capture_en,
   output logic [7:0]              line_err_cnt
);
   localparam int SW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [DATA_WIDTH-1:0] ZB = '0;
   logic                    vsync_r, href_r, fv, fv_d;
   logic [DATA_WIDTH-1:0]   data_r, b0, b1;
   logic [1:0]              mode_l, byte_cnt, last;
   logic [3:0]              wait_cnt;
   logic [SW-1:0]           sec_cnt;
   logic [7:0]              frm_cnt;
   logic                    frame_start, frame_end, pix_done, trunc, sec_wrap;
   logic [3*DATA_WIDTH-1:0] pix;
   always_comb begin
      fv          = vsync_r == VSYNC_VALID;
      frame_start = fv && !fv_d;
      frame_end   = !fv && fv_d;
      last        = mode_l == 2'd1 ? 2'd1 : mode_l == 2'd2 ? 2'd2 : 2'd0;
      pix_done    = href_r && byte_cnt == last;
      // href dropping before the last byte of a pixel leaves byte_cnt non-zero for one cycle
      trunc       = !href_r && byte_cnt != 2'd0;
      sec_wrap    = sec_cnt == SW'(CLK_FREQ - 1);
      pix         = mode_l == 2'd1 ? {ZB, b0, data_r} : mode_l == 2'd2 ? {b0, b1, data_r} : {ZB, ZB, data_r};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // idle level of vsync, so no spurious frame start appears after reset
         vsync_r          <= ~VSYNC_VALID;
         href_r           <= 1'b0;
         data_r           <= '0;
         fv_d             <= 1'b0;
         mode_l           <= 2'd0;
         byte_cnt         <= 2'd0;
         b0               <= '0;
         b1               <= '0;
         wait_cnt         <= 4'd0;
         capture_en       <= 1'b0;
         cmos_frame_vsync <= 1'b0;
         cmos_frame_href  <= 1'b0;
         cmos_frame_clken <= 1'b0;
         cmos_frame_data  <= '0;
         line_err_cnt     <= 8'd0;
         sec_cnt          <= '0;
         frm_cnt          <= 8'd0;
         cmos_fps_rate    <= 8'd0;
      end else begin
         vsync_r  <= cmos_vsync;
         href_r   <= cmos_href;
         data_r   <= cmos_data;
         fv_d     <= fv;
         if (frame_start) mode_l <= mode;
         byte_cnt <= (pix_done || !href_r) ? 2'd0 : byte_cnt + 2'd1;
         if (href_r && byte_cnt == 2'd0) b0 <= data_r;
         if (href_r && byte_cnt == 2'd1) b1 <= data_r;
         if (frame_end && wait_cnt < FRAME_WAITCNT) wait_cnt <= wait_cnt + 4'd1;
         capture_en       <= wait_cnt == FRAME_WAITCNT;
         cmos_frame_vsync <= capture_en && fv;
         cmos_frame_href  <= capture_en && href_r;
         cmos_frame_clken <= capture_en && pix_done;
         if (capture_en && pix_done) cmos_frame_data <= pix;
         if (trunc && line_err_cnt != 8'hFF) line_err_cnt <= line_err_cnt + 8'd1;
         sec_cnt <= sec_wrap ? '0 : sec_cnt + SW'(1);
         // a frame end on the wrap cycle belongs to the new window
         if (sec_wrap) begin
            cmos_fps_rate <= frm_cnt;
            frm_cnt       <= {7'd0, frame_end};
         end else if (frame_end && frm_cnt != 8'hFF) begin
            frm_cnt <= frm_cnt + 8'd1;
         end
      end
   end
endmodule
